ones_cnt_sched: RTL and testbench

ONES_CNT_SCHED -- requirements
Module: ones_cnt_sched

---
 rtl/ones_cnt_pkg.sv | 17 +
 rtl/ones_count.sv | 17 +
 rtl/ones_cnt_sched.sv | 125 ++++++++++++
 tb/tb_ones_cnt_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ones_cnt_pkg.sv
// Shared constants, state encoding and helpers for the ones-count scheduler.
package ones_cnt_pkg;

    localparam int unsigned OnesDw = 8;
    localparam int unsigned OnesSw = 8;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDone
    } state_e;

    function automatic logic [1:0] grant_of(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ones_count.sv
// Combinational population count of one data byte.
module ones_count #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 4
) (
    input  logic [DW-1:0] data_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < DW; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule

// File: rtl/ones_cnt_sched.sv
// Two-requester round-robin scheduler that sums the ones in each granted burst
// and reports the saturated total with a one-cycle strobe.
module ones_cnt_sched
    import ones_cnt_pkg::*;
#(
    parameter int unsigned DW = OnesDw,
    parameter int unsigned SW = OnesSw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [DW-1:0] dat0,
    input  logic [DW-1:0] dat1,
    input  logic [1:0]    last,
    output logic [1:0]    gnt,
    output logic          acc_vld,
    output logic          acc_id,
    output logic [SW-1:0] acc_sum,
    output logic          busy
);

    localparam int unsigned CntW = $clog2(DW + 1);

    state_e        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          owner_q, owner_d;
    logic          ptr_q, ptr_d;
    logic          fin_q, fin_d;
    logic          acc_vld_q, acc_vld_d;
    logic          acc_id_q, acc_id_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] acc_sum_q, acc_sum_d;

    logic [DW-1:0] byte_sel;
    logic [CntW-1:0] byte_ones;
    logic [SW:0]   sum_wide;

    assign byte_sel = owner_q ? dat1 : dat0;

    ones_count #(
        .DW(DW),
        .CW(CntW)
    ) u_ones_count (
        .data_i (byte_sel),
        .count_o(byte_ones)
    );

    // One extra bit catches the carry so the sum clamps instead of wrapping.
    assign sum_wide = {1'b0, acc_q} + (SW + 1)'(byte_ones);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        fin_d     = fin_q;
        acc_vld_d = 1'b0;
        acc_id_d  = acc_id_q;
        acc_d     = acc_q;
        acc_sum_d = acc_sum_q;
        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    owner_d = (req == 2'b11) ? ptr_q : req[1];
                    gnt_d   = grant_of(owner_d);
                    acc_d   = '0;
                    fin_d   = 1'b0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                // fin_q marks the drain cycle after the last byte; no more accepts.
                if (fin_q) begin
                    state_d   = StDone;
                    acc_vld_d = 1'b1;
                    acc_id_d  = owner_q;
                    acc_sum_d = acc_q;
                end else if (req[owner_q]) begin
                    acc_d = sum_wide[SW] ? {SW{1'b1}} : sum_wide[SW-1:0];
                    if (last[owner_q]) begin
                        fin_d = 1'b1;
                        gnt_d = 2'b00;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                fin_d   = 1'b0;
                ptr_d   = ~owner_q;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= 2'b00;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            fin_q     <= 1'b0;
            acc_vld_q <= 1'b0;
            acc_id_q  <= 1'b0;
            acc_q     <= '0;
            acc_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            fin_q     <= fin_d;
            acc_vld_q <= acc_vld_d;
            acc_id_q  <= acc_id_d;
            acc_q     <= acc_d;
            acc_sum_q <= acc_sum_d;
        end
    end

    assign gnt     = gnt_q;
    assign acc_vld = acc_vld_q;
    assign acc_id  = acc_id_q;
    assign acc_sum = acc_sum_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_ones_cnt_sched.sv
// Directed bench for ones_cnt_sched with a transaction-level reference model.
module tb_ones_cnt_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] dat0 = 8'h00;
    logic [7:0] dat1 = 8'h00;
    logic [1:0] last = 2'b00;
    logic [1:0] gnt;
    logic       acc_vld;
    logic       acc_id;
    logic [7:0] acc_sum;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    ones_cnt_sched dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .dat0   (dat0),
        .dat1   (dat1),
        .last   (last),
        .gnt    (gnt),
        .acc_vld(acc_vld),
        .acc_id (acc_id),
        .acc_sum(acc_sum),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: burst-level bookkeeping driven by the latency rules.
    int   cyc_n = 0;
    bit   m_active = 0;
    bit   m_own = 0;
    bit   m_ptr = 0;
    int   m_sum = 0;
    int   free_at = 0;
    int   vld_at = -10;
    int   pend_sum = 0;
    bit   pend_id = 0;
    logic [1:0] e_gnt = 2'b00;
    logic       e_vld = 1'b0;
    logic       e_id = 1'b0;
    logic [7:0] e_sum = 8'h00;
    logic       e_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_ptr = 0; m_sum = 0; free_at = 0; vld_at = -10;
            e_gnt = 2'b00; e_vld = 1'b0; e_id = 1'b0; e_sum = 8'h00; e_busy = 1'b0;
        end else begin
            cyc_n++;
            if (m_active) begin
                if (req[m_own]) begin
                    m_sum = m_sum + $countones(m_own ? dat1 : dat0);
                    if (m_sum > 255) m_sum = 255;
                    if (last[m_own]) begin
                        m_active = 0;
                        vld_at   = cyc_n + 1;
                        free_at  = cyc_n + 3;
                        pend_sum = m_sum;
                        pend_id  = m_own;
                        m_ptr    = !m_own;
                    end
                end
            end else if (cyc_n >= free_at && req != 2'b00) begin
                m_own    = (req == 2'b11) ? m_ptr : req[1];
                m_active = 1;
                m_sum    = 0;
            end
            e_vld = (cyc_n == vld_at);
            if (e_vld) begin
                e_sum = 8'(pend_sum);
                e_id  = pend_id;
            end
            e_gnt  = m_active ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            e_busy = m_active || (cyc_n < free_at - 1);
        end
    end

    int res_id[$];
    int res_sum[$];
    int gnt_ord[$];
    logic [1:0] prev_gnt = 2'b00;

    always @(negedge clk) begin
        check("gnt", {30'd0, gnt}, {30'd0, e_gnt});
        check("gnt_onehot", {31'd0, gnt == 2'b11}, 32'd0);
        check("acc_vld", {31'd0, acc_vld}, {31'd0, e_vld});
        check("acc_id", {31'd0, acc_id}, {31'd0, e_id});
        check("acc_sum", {24'd0, acc_sum}, {24'd0, e_sum});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        if (acc_vld === 1'b1) begin
            res_id.push_back(int'(acc_id));
            res_sum.push_back(int'(acc_sum));
        end
        if (gnt != 2'b00 && prev_gnt == 2'b00) gnt_ord.push_back(int'(gnt[1]));
        prev_gnt = gnt;
    end

    task automatic cyc(input logic [1:0] r, input logic [1:0] l,
                       input logic [7:0] d0, input logic [7:0] d1);
        req = r; last = l; dat0 = d0; dat1 = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 2'b00, 8'h00, 8'h00);
    endtask

    task automatic pulse_reset();
        req = 2'b00; last = 2'b00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_one(input string name, input int base, input int id, input int sum);
        check({name, "_count"}, res_sum.size(), base + 1);
        if (res_sum.size() == base + 1) begin
            check({name, "_id"}, res_id[base], id);
            check({name, "_sum"}, res_sum[base], sum);
        end
    endtask

    int base;
    int gbase;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {24'd0, acc_sum}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Bytes 0x01, 0x03, 0xFF on requester 0 -> 1 + 2 + 8
        base = res_sum.size();
        cyc(2'b01, 2'b00, 8'h01, 8'h00);
        cyc(2'b01, 2'b00, 8'h01, 8'h00);
        cyc(2'b01, 2'b00, 8'h03, 8'h00);
        cyc(2'b01, 2'b01, 8'hFF, 8'h00);
        idle(6);
        expect_one("burst3", base, 0, 11);

        // Both requesting single-byte bursts from reset: 0,1,0,1
        pulse_reset();
        base = res_sum.size();
        gbase = gnt_ord.size();
        repeat (14) cyc(2'b11, 2'b11, 8'h01, 8'h03);
        idle(6);
        check("rr_count", gnt_ord.size(), gbase + 4);
        if (gnt_ord.size() == gbase + 4) begin
            check("rr_g0", gnt_ord[gbase], 0);
            check("rr_g1", gnt_ord[gbase + 1], 1);
            check("rr_g2", gnt_ord[gbase + 2], 0);
            check("rr_g3", gnt_ord[gbase + 3], 1);
        end
        check("rr_results", res_sum.size(), base + 4);
        if (res_sum.size() == base + 4) begin
            check("rr_sum0", res_sum[base], 1);
            check("rr_sum1", res_sum[base + 1], 2);
        end

        // Requester 1 single byte 0x00 -> one strobe, sum 0
        base = res_sum.size();
        cyc(2'b10, 2'b10, 8'hFF, 8'h00);
        cyc(2'b10, 2'b10, 8'hFF, 8'h00);
        idle(6);
        expect_one("single1", base, 1, 0);

        // 33 x 0xFF saturates
        base = res_sum.size();
        cyc(2'b01, 2'b00, 8'hFF, 8'h00);
        for (int i = 1; i <= 33; i++) cyc(2'b01, (i == 33) ? 2'b01 : 2'b00, 8'hFF, 8'h00);
        idle(6);
        expect_one("sat", base, 0, 255);

        // Bubble of 3 with junk data and a non-owner request in between
        base = res_sum.size();
        cyc(2'b01, 2'b00, 8'h0F, 8'h00);
        cyc(2'b01, 2'b00, 8'h0F, 8'h00);
        repeat (3) cyc(2'b10, 2'b10, 8'hFF, 8'hFF);
        cyc(2'b01, 2'b01, 8'hF0, 8'h00);
        idle(6);
        expect_one("bubble", base, 0, 8);

        // Reset mid-burst discards it; pointer returns to requester 0
        base = res_sum.size();
        cyc(2'b01, 2'b00, 8'hFF, 8'h00);
        cyc(2'b01, 2'b00, 8'hFF, 8'h00);
        cyc(2'b01, 2'b00, 8'hFF, 8'h00);
        req = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", {30'd0, gnt}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_sum", {24'd0, acc_sum}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);
        check("mid_rst_novld", res_sum.size(), base);
        cyc(2'b11, 2'b11, 8'h01, 8'h01);
        check("mid_rst_gnt0", {30'd0, gnt}, 32'd1);
        cyc(2'b11, 2'b11, 8'h01, 8'h01);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
